// File: rtl/qed_dup_scheduler.sv
// Request scheduler for the shared inverting datapath: issues each operand once,
// or twice in QED mode, and flags any mismatch between the two results.
module qed_dup_scheduler #(
    parameter int WIDTH    = 5,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             qed_mode,
    output logic [WIDTH-1:0] dp_in,
    input  logic [WIDTH-1:0] dp_out,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE_O, ISSUE_D, DRAIN} state_e;

    state_e                state_q;
    logic [WIDTH-1:0]      op_q;
    logic                  mode_q;
    logic [WIDTH-1:0]      res_q;
    logic [PIPE_LAT-1:0]   tag_vld_q;
    logic [PIPE_LAT-1:0]   tag_dup_q;
    logic                  resp_valid_q;
    logic [WIDTH-1:0]      resp_data_q;
    logic                  resp_err_q;
    logic                  err_sticky_q;
    logic [CNT_W-1:0]      err_cnt_q;

    logic issuing;
    logic tail_vld;
    logic tail_dup;
    logic mism;

    assign issuing  = (state_q == ISSUE_O) || (state_q == ISSUE_D);
    assign tail_vld = tag_vld_q[PIPE_LAT-1];
    assign tail_dup = tag_dup_q[PIPE_LAT-1];
    assign mism     = (dp_out != res_q);

    assign req_ready  = (state_q == IDLE);
    assign dp_in      = issuing ? op_q : '0;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            mode_q       <= 1'b0;
            res_q        <= '0;
            tag_vld_q    <= '0;
            tag_dup_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;

            // Tags track which datapath slot holds an original or duplicate result.
            for (int i = 0; i < PIPE_LAT; i++) begin
                if (i == 0) begin
                    tag_vld_q[i] <= issuing;
                    tag_dup_q[i] <= (state_q == ISSUE_D);
                end else begin
                    tag_vld_q[i] <= tag_vld_q[i-1];
                    tag_dup_q[i] <= tag_dup_q[i-1];
                end
            end

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_data;
                        mode_q  <= qed_mode;
                        state_q <= ISSUE_O;
                    end
                end
                ISSUE_O: state_q <= mode_q ? ISSUE_D : DRAIN;
                ISSUE_D: state_q <= DRAIN;
                DRAIN:   state_q <= DRAIN;
                default: state_q <= IDLE;
            endcase

            if (tail_vld && !tail_dup) begin
                res_q <= dp_out;
                if (!mode_q) begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= dp_out;
                    resp_err_q   <= 1'b0;
                    state_q      <= IDLE;
                end
            end

            if (tail_vld && tail_dup) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= res_q;
                resp_err_q   <= mism;
                if (mism) begin
                    err_sticky_q <= 1'b1;
                    if (err_cnt_q != '1)
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: doc/qed_dup_scheduler.md
# qed_dup_scheduler

Request scheduler and checker for the shared bit-inverting register datapath (input register stage followed by an inverting output register stage, two-cycle latency). Accepts one request at a time over a valid/ready handshake, issues it into the datapath and, in QED mode, reissues the same operand as a duplicate and compares both results. Returns the result with a per-response error flag, plus sticky and counted error status for the formal/QED harness.

## Interface
- WIDTH, 5, operand/result width, matching the datapath bus.
- PIPE_LAT, 2, datapath latency in cycles from dp_in driven to dp_out valid.
- CNT_W, 8, width of the saturating error counter.

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_data  in  WIDTH  operand.
- qed_mode  in  1  sampled at accept; 1 = issue original plus duplicate.
- dp_in  out  WIDTH  datapath input; combinational from state and latched operand.
- dp_out  in  WIDTH  datapath output.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  WIDTH  result of the original issue.
- resp_err  out  1  valid with resp_valid; duplicate result mismatched the original.
- err_sticky  out  1  set on any mismatch; cleared only by reset.
- err_cnt  out  CNT_W  saturating mismatch count.

## Operation
- States: IDLE, ISSUE_O, ISSUE_D, DRAIN.
- IDLE: req_ready=1. On req_valid, latch req_data into op_q and qed_mode into mode_q, then go to ISSUE_O.
- ISSUE_O: dp_in=op_q; push tag {valid=1, dup=0} into the PIPE_LAT-deep tag shift register. Next state is ISSUE_D if mode_q=1, else DRAIN.
- ISSUE_D: dp_in=op_q; push tag {valid=1, dup=1}; go to DRAIN.
- All other states: dp_in=0 and the pushed tag is invalid.
- Tag tail valid with dup=0 marks the cycle in which dp_out holds the original result:
  - capture res_q<=dp_out;
  - if mode_q=0, also assert resp_valid, resp_data<=dp_out, resp_err<=0, and go to IDLE.
- Tag tail valid with dup=1:
  - mism = (dp_out != res_q);
  - assert resp_valid, resp_data<=res_q, resp_err<=mism;
  - if mism, set err_sticky and increment err_cnt, saturating at all-ones;
  - go to IDLE.
- At most one request is in flight; req_data/qed_mode changes after accept have no effect.
- Reset (async, any state): state=IDLE, tags cleared, op_q/res_q=0, all outputs 0 except req_ready=1. The datapath has no reset, so any dp_out values in flight are ignored: tags are cleared, so nothing is captured.
- Arithmetic: equality compare only; err_cnt never wraps.

## Timing
- Accept edge ends cycle T.
- ISSUE_O is cycle T+1; ISSUE_D is T+2 in QED mode.
- Original result on dp_out in T+1+PIPE_LAT = T+3; duplicate result in T+4.
- resp_valid high in cycle T+4 (non-QED) or T+5 (QED), registered, one cycle.
- req_ready rises in the same cycle as resp_valid, so a new accept is possible at the end of that cycle.
- Peak throughput: one request per 4 cycles (non-QED) or 5 cycles (QED).
- Reset values: req_ready=1; resp_valid=0; resp_data=0; resp_err=0; err_sticky=0; err_cnt=0; dp_in=0.
- req_valid while req_ready=0 is ignored; the requester must hold it.

## Test plan
- Non-QED: req_data=5'b10101, qed_mode=0 accepted at T -> dp_in=10101 only in T+1; resp_valid at T+4 with resp_data=01010, resp_err=0.
- QED, healthy datapath: req_data=5'b00111, qed_mode=1 -> dp_in=00111 in T+1 and T+2; resp at T+5 with data=11000, resp_err=0; err_cnt stays 0.
- QED, fault: force dp_out=5'b11001 only in the duplicate cycle for op 00111 -> resp_data=11000, resp_err=1, err_sticky=1, err_cnt=1.
- Back-to-back with req_valid held high and alternating modes -> accepts at T, T+4, then T+9; req_ready low between accepts; responses in order.
- Saturation: 260 forced mismatches with CNT_W=8 -> err_cnt=255, no wrap.
- Reset mid-op: assert rst_n=0 during ISSUE_D -> all outputs at reset values immediately, no resp_valid afterwards; next request behaves normally.
